// File: rtl/btn_pkg.sv
// Shared types and default constants for the push-button debounce/interrupt block.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE_LOW,
    WAIT_HIGH,
    HELD_HIGH,
    WAIT_LOW
  } db_state_t;

  localparam int DEBOUNCE_CYCLES_DEF = 500000;
  localparam int PULSE_CYCLES_DEF    = 4;

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchroniser for asynchronous switch/button inputs.
module btn_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/btn_debounce_intr.sv
// Debounces a raw button and emits a stretched interrupt pulse per accepted press,
// along with the debounced level and a modulo-256 press count.
module btn_debounce_intr
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int PULSE_CYCLES    = PULSE_CYCLES_DEF
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       BTN,
  output logic       DB_LEVEL,
  output logic       INTR,
  output logic [7:0] PRESS_COUNT
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int PW = $clog2(PULSE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] PULSE_LOAD = PW'(PULSE_CYCLES);

  logic sync;

  btn_sync u_sync (
    .clk_i  (CLK),
    .rst_ni (RST_N),
    .d_i    (BTN),
    .q_o    (sync)
  );

  db_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] pulse_q, pulse_d;
  logic          db_q, db_d;
  logic          intr_q, intr_d;
  logic [7:0]    press_q, press_d;
  logic          accept;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE_LOW;
      cnt_q   <= '0;
      pulse_q <= '0;
      db_q    <= 1'b0;
      intr_q  <= 1'b0;
      press_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      db_q    <= db_d;
      intr_q  <= intr_d;
      press_q <= press_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    db_d    = db_q;
    accept  = 1'b0;
    unique case (state_q)
      IDLE_LOW: begin
        if (sync) begin
          state_d = WAIT_HIGH;
          cnt_d   = '0;
        end
      end
      WAIT_HIGH: begin
        if (!sync) begin
          state_d = IDLE_LOW;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HELD_HIGH;
          db_d    = 1'b1;
          accept  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HELD_HIGH: begin
        if (!sync) begin
          state_d = WAIT_LOW;
          cnt_d   = '0;
        end
      end
      WAIT_LOW: begin
        if (sync) begin
          state_d = HELD_HIGH;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_LOW;
          db_d    = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE_LOW;
    endcase
  end

  // Reload on accept even mid-pulse so INTR stays high without a gap.
  always_comb begin
    pulse_d = pulse_q;
    press_d = press_q;
    if (accept) begin
      pulse_d = PULSE_LOAD;
      press_d = press_q + 8'd1;
    end else if (pulse_q != '0) begin
      pulse_d = pulse_q - 1'b1;
    end
    intr_d = (pulse_d != '0);
  end

  assign DB_LEVEL    = db_q;
  assign INTR        = intr_q;
  assign PRESS_COUNT = press_q;

endmodule

// File: tb/tb_btn_debounce_intr.sv
// Directed bench for btn_debounce_intr with a run-length behavioural model.
module tb_btn_debounce_intr;

  localparam int D = 8;
  localparam int P = 4;

  logic       CLK;
  logic       RST_N;
  logic       BTN;
  logic       DB_LEVEL;
  logic       INTR;
  logic [7:0] PRESS_COUNT;

  int errors = 0;
  int checks = 0;

  btn_debounce_intr #(
    .DEBOUNCE_CYCLES (D),
    .PULSE_CYCLES    (P)
  ) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .BTN         (BTN),
    .DB_LEVEL    (DB_LEVEL),
    .INTR        (INTR),
    .PRESS_COUNT (PRESS_COUNT)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: the FSM sees BTN two edges late; a new level is accepted once it
  // has been observed on D+1 consecutive edges without interruption.
  bit dq[$];
  bit samp;
  bit m_lvl;
  int m_run;
  int m_pulse;
  int m_cnt;

  initial begin
    dq = '{1'b0, 1'b0};
    m_lvl = 0; m_run = 0; m_pulse = 0; m_cnt = 0;
    forever begin
      @(posedge CLK or negedge RST_N);
      if (!RST_N) begin
        dq = '{1'b0, 1'b0};
        m_lvl = 0; m_run = 0; m_pulse = 0; m_cnt = 0;
      end else begin
        dq.push_back(BTN);
        samp = dq.pop_front();
        if (m_pulse > 0) m_pulse--;
        if (samp != m_lvl) begin
          m_run++;
          if (m_run == D + 1) begin
            m_lvl = samp;
            m_run = 0;
            if (samp) begin
              m_pulse = P;
              m_cnt = (m_cnt + 1) % 256;
            end
          end
        end else begin
          m_run = 0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge CLK);
      if (!RST_N) begin
        chk("rst_db", int'(DB_LEVEL), 0);
        chk("rst_intr", int'(INTR), 0);
        chk("rst_cnt", int'(PRESS_COUNT), 0);
      end else begin
        chk("mdl_db", int'(DB_LEVEL), int'(m_lvl));
        chk("mdl_intr", int'(INTR), int'(m_pulse > 0));
        chk("mdl_cnt", int'(PRESS_COUNT), m_cnt);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic chk3(input string nm, input int db, input int in, input int pc);
    chk({nm, "_db"}, int'(DB_LEVEL), db);
    chk({nm, "_intr"}, int'(INTR), in);
    chk({nm, "_cnt"}, int'(PRESS_COUNT), pc);
  endtask

  initial begin
    BTN   = 1'b0;
    RST_N = 1'b1;
    #1 RST_N = 1'b0;
    #1 chk3("reset_now", 0, 0, 0);
    tick(3);
    chk3("reset_hold", 0, 0, 0);
    RST_N = 1'b1;
    tick(2);
    chk3("reset_after", 0, 0, 0);

    // Clean press: first sampling edge is the next edge.
    BTN = 1'b1;
    tick(10); chk3("press_e10", 0, 0, 0);
    tick(1);  chk3("press_e11", 1, 1, 1);
    tick(3);  chk("press_e14_intr", int'(INTR), 1);
    tick(1);  chk("press_e15_intr", int'(INTR), 0);
    tick(15);
    BTN = 1'b0;
    tick(10); chk("rel_e10_db", int'(DB_LEVEL), 1);
    tick(1);  chk3("rel_e11", 0, 0, 1);
    tick(5);

    // Bounce then hold.
    BTN = 1'b1; tick(3);
    BTN = 1'b0; tick(3);
    BTN = 1'b1; tick(3);
    BTN = 1'b0; tick(3);
    BTN = 1'b1;
    tick(10); chk3("bounce_e10", 0, 0, 1);
    tick(1);  chk3("bounce_e11", 1, 1, 2);
    tick(4);  chk("bounce_end_intr", int'(INTR), 0);

    // Short release glitch while held.
    BTN = 1'b0; tick(5);
    BTN = 1'b1; tick(20);
    chk3("glitch", 1, 0, 2);
    BTN = 1'b0; tick(20);
    chk3("glitch_rel", 0, 0, 2);

    // Wrap of press count.
    RST_N = 1'b0; tick(2);
    RST_N = 1'b1; tick(2);
    for (int i = 1; i <= 257; i++) begin
      BTN = 1'b1; tick(14);
      BTN = 1'b0; tick(14);
      if (i == 255) chk("wrap_255", int'(PRESS_COUNT), 255);
      if (i == 256) chk("wrap_256", int'(PRESS_COUNT), 0);
      if (i == 257) chk("wrap_257", int'(PRESS_COUNT), 1);
    end

    // Reset while debouncing a held press (cnt=5 after edge 8).
    BTN = 1'b1;
    tick(8);
    RST_N = 1'b0;
    #1 chk3("midrst_now", 0, 0, 0);
    tick(3);  chk3("midrst_hold", 0, 0, 0);
    RST_N = 1'b1;
    tick(10); chk3("midrst_e10", 0, 0, 0);
    tick(1);  chk3("midrst_e11", 1, 1, 1);
    tick(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
